// File: rtl/matrix_op_sequencer_if.sv
// rtl/matrix_op_sequencer_if.sv - user/memory side bus of the matrix operation sequencer
interface matrix_op_sequencer_if #(
  parameter int ELEM_W = 9,
  parameter int MAX_N  = 5
);
  localparam int MAT_W = MAX_N * MAX_N * ELEM_W;

  logic              start;
  logic [2:0]        operacao;
  logic [4:0]        tamanho;
  logic [ELEM_W-1:0] scalar;
  logic              load_req;
  logic              load_ack;
  logic [MAT_W-1:0]  matriz_a;
  logic [MAT_W-1:0]  matriz_b;
  logic [MAT_W-1:0]  matriz_c;
  logic              busy;
  logic              done;
  logic              erro;
  logic              overflow;

  // user inputs and matrix memory side
  modport master (
    output start, operacao, tamanho, scalar, load_ack, matriz_a, matriz_b,
    input  load_req, matriz_c, busy, done, erro, overflow
  );

  // sequencer side
  modport slave (
    input  start, operacao, tamanho, scalar, load_ack, matriz_a, matriz_b,
    output load_req, matriz_c, busy, done, erro, overflow
  );
endinterface

// File: rtl/matrix_op_sequencer.sv
// rtl/matrix_op_sequencer.sv - 5x5 matrix coprocessor control unit and element datapath
module matrix_op_sequencer #(
  parameter int ELEM_W      = 9,
  parameter int MAX_N       = 5,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  matrix_op_sequencer_if.slave  bus
);
  localparam int MAT_W = MAX_N * MAX_N * ELEM_W;
  localparam int ACC_W = 2 * ELEM_W + 3;
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_DONE} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [2:0]                r_op;
  logic [4:0]                r_n;
  logic signed [ELEM_W-1:0]  r_scalar;
  logic [MAT_W-1:0]          r_a;
  logic [MAT_W-1:0]          r_b;
  logic [MAT_W-1:0]          r_c;
  logic [2:0]                r_i;
  logic [2:0]                r_j;
  logic [2:0]                r_k;
  logic [TMO_W-1:0]          r_tmo;
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_erro;
  logic                      r_ovf;

  logic                      w_valid;
  logic                      w_timeout;
  logic                      w_is_mul;
  logic [4:0]                w_nm1;
  logic                      w_i_last;
  logic                      w_j_last;
  logic                      w_k_last;
  logic                      w_last;
  logic                      w_wr;
  logic [4:0]                w_idx_wr;
  logic signed [ACC_W-1:0]   w_a_ij;
  logic signed [ACC_W-1:0]   w_b_ij;
  logic signed [ACC_W-1:0]   w_scl;
  logic signed [ACC_W-1:0]   w_elem;
  logic signed [ACC_W-1:0]   w_acc_base;
  logic signed [ACC_W-1:0]   w_acc_next;
  logic signed [ACC_W-1:0]   w_res;
  logic                      w_ovf;
  logic                      w_load_req;
  logic                      w_busy;
  logic                      w_done;

  // Sign-extended element at flat index idx of a packed matrix.
  function automatic logic signed [ACC_W-1:0] elem(input logic [MAT_W-1:0] m, input logic [4:0] idx);
    elem = ACC_W'($signed(m[idx*ELEM_W +: ELEM_W]));
  endfunction

  // Flat slot of (row, col) in the fixed MAX_N x MAX_N layout.
  function automatic logic [4:0] flat(input logic [2:0] row, input logic [2:0] col);
    flat = 5'(row) * 5'(MAX_N) + 5'(col);
  endfunction

  assign w_valid   = (bus.operacao <= 3'd5) && (bus.tamanho >= 5'd2) && (bus.tamanho <= 5'(MAX_N));
  assign w_timeout = (r_tmo == TMO_W'(ACK_TIMEOUT - 1));
  assign w_is_mul  = (r_op == 3'b010);
  assign w_nm1     = r_n - 5'd1;
  assign w_i_last  = (5'(r_i) == w_nm1);
  assign w_j_last  = (5'(r_j) == w_nm1);
  assign w_k_last  = (5'(r_k) == w_nm1);
  assign w_wr      = !w_is_mul || w_k_last;
  assign w_last    = w_i_last && w_j_last && w_wr;
  assign w_idx_wr  = (r_op == 3'b100) ? flat(r_j, r_i) : flat(r_i, r_j);

  assign w_a_ij     = elem(r_a, flat(r_i, r_j));
  assign w_b_ij     = elem(r_b, flat(r_i, r_j));
  assign w_scl      = ACC_W'(r_scalar);
  assign w_acc_base = (r_k == 3'd0) ? '0 : r_acc;
  assign w_acc_next = w_acc_base + elem(r_a, flat(r_i, r_k)) * elem(r_b, flat(r_k, r_j));
  assign w_res      = w_is_mul ? w_acc_next : w_elem;
  // Full-precision value does not survive truncation to ELEM_W bits.
  assign w_ovf      = (w_res != ACC_W'($signed(w_res[ELEM_W-1:0])));

  // Per-element result for the single-cycle operations.
  always_comb begin
    w_elem = '0;
    case (r_op)
      3'b000:  w_elem = w_a_ij + w_b_ij;
      3'b001:  w_elem = w_a_ij - w_b_ij;
      3'b011:  w_elem = w_a_ij * w_scl;
      3'b100:  w_elem = w_a_ij;
      3'b101:  w_elem = -w_a_ij;
      default: w_elem = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state and Moore outputs.
  always_comb begin
    w_next     = r_state;
    w_load_req = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = w_valid ? S_LOAD : S_DONE;
      end
      S_LOAD: begin
        w_load_req = 1'b1;
        w_busy     = 1'b1;
        if (bus.load_ack)  w_next = S_EXEC;
        else if (w_timeout) w_next = S_DONE;
      end
      S_EXEC: begin
        w_busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, counters, result writes and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op     <= '0;
      r_n      <= '0;
      r_scalar <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_tmo    <= '0;
      r_acc    <= '0;
      r_erro   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op     <= bus.operacao;
            r_n      <= bus.tamanho;
            r_scalar <= bus.scalar;
            r_c      <= '0;
            r_erro   <= !w_valid;
            r_ovf    <= 1'b0;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_tmo    <= '0;
            r_acc    <= '0;
          end
        end
        S_LOAD: begin
          if (bus.load_ack) begin
            r_a <= bus.matriz_a;
            r_b <= bus.matriz_b;
          end else if (w_timeout) begin
            r_erro <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_EXEC: begin
          r_acc <= w_acc_next;
          if (w_wr) begin
            r_c[w_idx_wr*ELEM_W +: ELEM_W] <= w_res[ELEM_W-1:0];
            if (w_ovf) r_ovf <= 1'b1;
          end
          if (w_is_mul && !w_k_last) begin
            r_k <= r_k + 3'd1;
          end else begin
            r_k <= '0;
            if (!w_j_last) begin
              r_j <= r_j + 3'd1;
            end else begin
              r_j <= '0;
              r_i <= r_i + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.load_req = w_load_req;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.matriz_c = r_c;
  assign bus.erro     = r_erro;
  assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_matrix_op_sequencer.sv
// tb/tb_matrix_op_sequencer.sv - directed table-driven bench for matrix_op_sequencer
module tb_matrix_op_sequencer;
  localparam int MW = 225;

  typedef struct {
    logic [2:0]    op;
    logic [4:0]    n;
    logic [8:0]    scal;
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    int            ack_dly;
    int            start_at_exec;
    logic [MW-1:0] c;
    logic          erro;
    logic          ovf;
    int            exec;
    int            load;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;

  matrix_op_sequencer_if #(.ELEM_W(9), .MAX_N(5)) ifc ();

  matrix_op_sequencer #(.ELEM_W(9), .MAX_N(5), .ACK_TIMEOUT(255)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] mset(input logic [MW-1:0] m, input int i, input int j, input int val);
    logic [31:0] t;
    t = val;
    m[(i*5+j)*9 +: 9] = t[8:0];
    return m;
  endfunction

  // element (i,j) = base + step*(i*n+j) inside the n x n corner, 0 elsewhere
  function automatic logic [MW-1:0] mseq(input int n, input int base, input int step);
    logic [MW-1:0] m;
    m = '0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        m = mset(m, i, j, base + step * (i * n + j));
    return m;
  endfunction

  function automatic logic [MW-1:0] mident(input int n);
    logic [MW-1:0] m;
    m = '0;
    for (int i = 0; i < n; i++) m = mset(m, i, i, 1);
    return m;
  endfunction

  // transpose of mseq(5,1,1): C[r][c] = c*5 + r + 1
  function automatic logic [MW-1:0] mtr5();
    logic [MW-1:0] m;
    m = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        m = mset(m, r, c, c * 5 + r + 1);
    return m;
  endfunction

  function automatic vec_t mkv(input logic [2:0] op, input logic [4:0] n, input logic [8:0] scal,
                               input logic [MW-1:0] a, input logic [MW-1:0] b, input int dly,
                               input int sx, input logic [MW-1:0] c, input logic erro,
                               input logic ovf, input int ex, input int ld);
    vec_t v;
    v.op = op; v.n = n; v.scal = scal; v.a = a; v.b = b; v.ack_dly = dly;
    v.start_at_exec = sx; v.c = c; v.erro = erro; v.ovf = ovf; v.exec = ex; v.load = ld;
    return v;
  endfunction

  // Acts as user plus matrix memory; counts LOAD and EXEC cycles until done.
  task automatic run_op(input vec_t t, output int ex, output int ld, output logic ok);
    int guard;
    ifc.operacao = t.op;
    ifc.tamanho  = t.n;
    ifc.scalar   = t.scal;
    ifc.matriz_a = t.a;
    ifc.matriz_b = t.b;
    ifc.start    = 1'b1;
    tick();
    ifc.start = 1'b0;
    ex = 0; ld = 0; guard = 0;
    while (!ifc.done && guard < 1000) begin
      ifc.start = (ifc.busy && !ifc.load_req && ex == t.start_at_exec);
      if (ifc.load_req) begin
        ld++;
        ifc.load_ack = (t.ack_dly >= 0 && ld == t.ack_dly + 1);
      end else begin
        ifc.load_ack = 1'b0;
      end
      if (ifc.busy && !ifc.load_req) ex++;
      tick();
      guard++;
    end
    ifc.load_ack = 1'b0;
    ifc.start    = 1'b0;
    ok = ifc.done;
  endtask

  task automatic check_run(input string nm, input vec_t t);
    int ex, ld;
    logic ok;
    run_op(t, ex, ld, ok);
    chk({nm, " done"}, MW'(ok), MW'(1));
    chk({nm, " busy"}, MW'(ifc.busy), MW'(0));
    chk({nm, " matriz_c"}, ifc.matriz_c, t.c);
    chk({nm, " erro"}, MW'(ifc.erro), MW'(t.erro));
    chk({nm, " overflow"}, MW'(ifc.overflow), MW'(t.ovf));
    chk({nm, " exec_cycles"}, MW'(ex), MW'(t.exec));
    chk({nm, " load_cycles"}, MW'(ld), MW'(t.load));
    tick();
    chk({nm, " done_one_cycle"}, MW'(ifc.done), MW'(0));
  endtask

  task automatic check_idle(input string nm);
    chk({nm, " load_req"}, MW'(ifc.load_req), MW'(0));
    chk({nm, " busy"}, MW'(ifc.busy), MW'(0));
    chk({nm, " done"}, MW'(ifc.done), MW'(0));
    chk({nm, " erro"}, MW'(ifc.erro), MW'(0));
    chk({nm, " overflow"}, MW'(ifc.overflow), MW'(0));
    chk({nm, " matriz_c"}, ifc.matriz_c, MW'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[15];
    int   ex;
    int   g;
    vec_t t;
    logic ok;

    tbl[0]  = mkv(3'b000, 5'd2, 9'd0, mseq(2,1,1), mseq(2,5,1), 1, -1, mseq(2,6,2), 0, 0, 4, 2);
    tbl[1]  = mkv(3'b010, 5'd3, 9'd0, mident(3), mseq(3,1,1), 1, -1, mseq(3,1,1), 0, 0, 27, 2);
    tbl[2]  = mkv(3'b010, 5'd3, 9'd0, mseq(3,2,0), mseq(3,3,0), 2, -1, mseq(3,18,0), 0, 0, 27, 3);
    tbl[3]  = mkv(3'b000, 5'd2, 9'd0, mset('0,0,0,200), mset('0,0,0,100), 0, -1,
                  mset('0,0,0,-212), 0, 1, 4, 1);
    tbl[4]  = mkv(3'b001, 5'd2, 9'd0, mseq(2,1,1), mseq(2,5,1), 0, -1, mseq(2,-4,0), 0, 0, 4, 1);
    tbl[5]  = mkv(3'b011, 5'd3, 9'h1FD, mseq(3,1,1), '0, 0, -1, mseq(3,-3,-3), 0, 0, 9, 1);
    tbl[6]  = mkv(3'b101, 5'd4, 9'd0, mset(mseq(4,7,0),0,0,-256), '0, 0, -1,
                  mset(mseq(4,-7,0),0,0,-256), 0, 1, 16, 1);
    tbl[7]  = mkv(3'b000, 5'd6, 9'd0, mseq(2,1,1), mseq(2,1,1), 0, -1, '0, 1, 0, 0, 0);
    tbl[8]  = mkv(3'b111, 5'd3, 9'd0, mseq(3,1,1), mseq(3,1,1), 0, -1, '0, 1, 0, 0, 0);
    tbl[9]  = mkv(3'b000, 5'd1, 9'd0, mseq(1,1,1), mseq(1,1,1), 0, -1, '0, 1, 0, 0, 0);
    tbl[10] = mkv(3'b100, 5'd5, 9'd0, mseq(5,1,1), '0, 3, 10, mtr5(), 0, 0, 25, 4);
    tbl[11] = mkv(3'b000, 5'd5, 9'd0, mseq(5,1,1), mseq(5,100,0), 0, -1, mseq(5,101,1), 0, 0, 25, 1);
    tbl[12] = mkv(3'b000, 5'd2, 9'd0, mseq(2,1,1), mseq(2,1,1), -1, -1, '0, 1, 0, 0, 255);
    tbl[13] = mkv(3'b010, 5'd2, 9'd0, mseq(2,16,0), mseq(2,16,0), 0, -1, '0, 0, 1, 8, 1);
    tbl[14] = mkv(3'b000, 5'd2, 9'd0, mseq(2,200,0), mseq(2,55,0), 0, -1, mseq(2,255,0), 0, 0, 4, 1);

    reset        = 1'b1;
    ifc.start    = 1'b0;
    ifc.operacao = '0;
    ifc.tamanho  = '0;
    ifc.scalar   = '0;
    ifc.load_ack = 1'b0;
    ifc.matriz_a = '0;
    ifc.matriz_b = '0;
    tick();
    tick();
    check_idle("reset");
    reset = 1'b0;

    for (int v = 0; v < 15; v++) check_run($sformatf("v%0d", v), tbl[v]);

    // reset one cycle in the middle of a 5x5 multiply
    ifc.operacao = 3'b010;
    ifc.tamanho  = 5'd5;
    ifc.matriz_a = mseq(5,3,0);
    ifc.matriz_b = mseq(5,3,0);
    ifc.start    = 1'b1;
    tick();
    ifc.start = 1'b0;
    ex = 0; g = 0;
    while (ex < 40 && g < 200) begin
      ifc.load_ack = ifc.load_req;
      if (ifc.busy && !ifc.load_req) ex++;
      tick();
      g++;
    end
    ifc.load_ack = 1'b0;
    chk("midexec reached", MW'(ex), MW'(40));
    chk("midexec partial_result", MW'(ifc.matriz_c != '0), MW'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("midexec_reset");
    tick();
    check_idle("post_reset_idle");

    t = mkv(3'b010, 5'd5, 9'd0, mident(5), mseq(5,1,1), 1, -1, mseq(5,1,1), 0, 0, 125, 2);
    check_run("fresh_mul5", t);

    // invalid start: done exactly one edge after the start edge
    t = mkv(3'b110, 5'd4, 9'd0, '0, '0, 0, -1, '0, 1, 0, 0, 0);
    run_op(t, ex, g, ok);
    chk("invalid110 done", MW'(ok && ex == 0 && g == 0), MW'(1));
    chk("invalid110 erro", MW'(ifc.erro), MW'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
